// File: rtl/morse_pkg.sv
// Shared Morse definitions: keying-state encoding and default unit constants,
// used by both the transmitter and the receiver.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        CGAP  = 2'd3
    } morse_state_e;

    localparam int DEFAULT_DOT_UNITS      = 1;
    localparam int DEFAULT_DASH_UNITS     = 3;
    localparam int DEFAULT_GAP_UNITS      = 1;
    localparam int DEFAULT_CHAR_GAP_UNITS = 3;
    localparam int DEFAULT_WORD_GAP_UNITS = 7;
    localparam int DEFAULT_TW             = 4;
    localparam int MAX_ELEMENTS           = 5;

    // Lengths above five elements are sent as five.
    function automatic logic [2:0] clampLen(input logic [2:0] l);
        return (l > 3'(MAX_ELEMENTS)) ? 3'(MAX_ELEMENTS) : l;
    endfunction

endpackage

// File: rtl/morse_tx_if.sv
// Character request / keying bundle between a character source and morse_tx.
interface morse_tx_if;
    logic       start;
    logic [2:0] len;
    logic [4:0] code;
    logic       key;
    logic       busy;
    logic       done;

    modport master (output start, output len, output code,
                    input  key,   input  busy, input  done);
    modport slave  (input  start, input  len,  input  code,
                    output key,   output busy, output done);
endinterface

// File: rtl/morse_unit_timer.sv
// Loadable unit down-counter; decrements on ce, flags the tick that ends a state.
module morse_unit_timer #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce_i,
    input  logic          load_i,
    input  logic [TW-1:0] loadVal_i,
    output logic          expire_o
);

    logic [TW-1:0] count_q;

    // A load wins over a coincident tick so every state gets its full unit count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= loadVal_i;
        end else if (ce_i && (count_q != '0)) begin
            count_q <= count_q - TW'(1);
        end
    end

    assign expire_o = ce_i && (count_q == TW'(1));

endmodule

// File: rtl/morse_tx.sv
// Morse keyer: sends one latched character (or a word gap) as timed marks and spaces.
module morse_tx
    import morse_pkg::*;
#(
    parameter int DOT_UNITS      = DEFAULT_DOT_UNITS,
    parameter int DASH_UNITS     = DEFAULT_DASH_UNITS,
    parameter int GAP_UNITS      = DEFAULT_GAP_UNITS,
    parameter int CHAR_GAP_UNITS = DEFAULT_CHAR_GAP_UNITS,
    parameter int WORD_GAP_UNITS = DEFAULT_WORD_GAP_UNITS,
    parameter int TW             = DEFAULT_TW
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     ce,
    morse_tx_if.slave bus
);

    localparam logic [TW-1:0] DotVal   = TW'(DOT_UNITS);
    localparam logic [TW-1:0] DashVal  = TW'(DASH_UNITS);
    localparam logic [TW-1:0] GapVal   = TW'(GAP_UNITS);
    localparam logic [TW-1:0] CharVal  = TW'(CHAR_GAP_UNITS);
    localparam logic [TW-1:0] WordVal  = TW'(WORD_GAP_UNITS);

    morse_state_e  state_q, state_d;
    logic [4:0]    code_q, code_d;
    logic [2:0]    len_q, len_d;
    logic [2:0]    elemIdx_q, elemIdx_d;
    logic          done_q, done_d;

    logic          timerLoad;
    logic [TW-1:0] timerVal;
    logic          timerExpire;
    logic [2:0]    reqLen;

    morse_unit_timer #(.TW(TW)) uTimer (
        .clk       (clk),
        .rst       (rst),
        .ce_i      (ce),
        .load_i    (timerLoad),
        .loadVal_i (timerVal),
        .expire_o  (timerExpire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            code_q    <= '0;
            len_q     <= '0;
            elemIdx_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            len_q     <= len_d;
            elemIdx_q <= elemIdx_d;
            done_q    <= done_d;
        end
    end

    assign reqLen = clampLen(bus.len);

    // Requests are only looked at in IDLE, so a start while busy is simply dropped.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        len_d     = len_q;
        elemIdx_d = elemIdx_q;
        done_d    = 1'b0;
        timerLoad = 1'b0;
        timerVal  = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    code_d    = bus.code;
                    len_d     = reqLen;
                    elemIdx_d = '0;
                    timerLoad = 1'b1;
                    if (reqLen == 3'd0) begin
                        state_d  = CGAP;
                        timerVal = WordVal;
                    end else begin
                        state_d  = MARK;
                        timerVal = bus.code[0] ? DashVal : DotVal;
                    end
                end
            end
            MARK: begin
                if (timerExpire) begin
                    timerLoad = 1'b1;
                    if ((elemIdx_q + 3'd1) < len_q) begin
                        state_d   = SPACE;
                        timerVal  = GapVal;
                        elemIdx_d = elemIdx_q + 3'd1;
                    end else begin
                        state_d  = CGAP;
                        timerVal = CharVal;
                    end
                end
            end
            SPACE: begin
                if (timerExpire) begin
                    state_d   = MARK;
                    timerLoad = 1'b1;
                    timerVal  = code_q[elemIdx_q] ? DashVal : DotVal;
                end
            end
            CGAP: begin
                if (timerExpire) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.key  = (state_q == MARK);
    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;

endmodule
